// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered display data,
// a ghosting guard interval, per-group leading-zero suppression and blinking.
module ssd_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 131072,
  parameter int GUARD        = 16,
  parameter int GROUP        = 4,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic [4*NUM_DIGITS-1:0] stg_digits, act_digits;
  logic [NUM_DIGITS-1:0]   stg_dp, act_dp;
  logic [NUM_DIGITS-1:0]   stg_blank, act_blank;
  logic [NUM_DIGITS-1:0]   stg_blink, act_blink;
  logic                    stg_lz, act_lz;

  logic scan_last, idx_last, frame_end;
  logic [NUM_DIGITS-1:0] sup;
  logic run;
  logic [3:0] cur_nib;
  logic cur_dark, cur_dp;

  assign scan_last  = (scan_cnt == SW'(SCAN_DIV - 1));
  assign idx_last   = (idx == IW'(NUM_DIGITS - 1));
  assign frame_end  = scan_last && idx_last;
  assign frame_tick = frame_end;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt    <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      stg_digits  <= '0;
      stg_dp      <= '0;
      stg_blank   <= '0;
      stg_blink   <= '0;
      stg_lz      <= 1'b0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
      act_blink   <= '0;
      act_lz      <= 1'b0;
    end else begin
      scan_cnt <= scan_last ? '0 : scan_cnt + 1'b1;
      if (scan_last)
        idx <= idx_last ? '0 : idx + 1'b1;
      // The active bank swaps only at frame end so a frame never tears.
      if (frame_end) begin
        act_digits <= stg_digits;
        act_dp     <= stg_dp;
        act_blank  <= stg_blank;
        act_blink  <= stg_blink;
        act_lz     <= stg_lz;
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      if (load) begin
        stg_digits <= digits;
        stg_dp     <= dp_in;
        stg_blank  <= blank_mask;
        stg_blink  <= blink_mask;
        stg_lz     <= lz_en;
      end
    end
  end

  // Walk each group from its MS digit down; run stays set while every digit so far is zero.
  always_comb begin
    sup = '0;
    run = 1'b0;
    for (int g = 0; g < NUM_DIGITS / GROUP; g++) begin
      run = act_lz;
      for (int j = GROUP - 1; j >= 1; j--) begin
        run = run && (act_digits[4*(g*GROUP+j) +: 4] == 4'h0);
        sup[g*GROUP+j] = run;
      end
    end
  end

  assign cur_nib  = act_digits[{idx, 2'b00} +: 4];
  assign cur_dp   = act_dp[idx];
  assign cur_dark = act_blank[idx] | (act_blink[idx] & blink_phase) | sup[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= (scan_cnt < SW'(GUARD)) ? '1 : ~(NUM_DIGITS'(1) << idx);
      seg <= cur_dark ? 7'h7F : glyph(cur_nib);
      dp  <= cur_dark | ~cur_dp;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Randomized bench for ssd_scan_driver against a cycle-position reference model
// that derives slot, digit and blink phase arithmetically from elapsed cycles.
module tb_ssd_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int G  = 1;
  localparam int GR = 4;
  localparam int BF = 2;
  localparam int FL = N * SD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*N-1:0] digits;
  logic [N-1:0]  dp_in, blank_mask, blink_mask;
  logic          lz_en, load;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          dp, frame_tick;

  int errors = 0;
  int checks = 0;

  int k;
  logic [15:0] st_dig, ac_dig;
  logic [3:0]  st_dp, ac_dp, st_bl, ac_bl, st_bk, ac_bk;
  logic        st_lz, ac_lz;

  always #5 clk = ~clk;

  ssd_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD(G), .GROUP(GR), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
    .load(load), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  function automatic logic [6:0] ref_glyph(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    return tbl[v];
  endfunction

  // A digit is a suppressed leading zero when it is not its group's LS digit
  // and it plus every higher digit in its group are all zero.
  function automatic bit ref_dark(input int i, input int frames);
    bit lz_sup;
    int top;
    if (ac_bl[i]) return 1;
    if (ac_bk[i] && ((frames / BF) % 2 == 1)) return 1;
    lz_sup = 0;
    if (ac_lz && (i % GR != 0)) begin
      lz_sup = 1;
      top = (i / GR) * GR + GR - 1;
      for (int j = i; j <= top; j++)
        if (ac_dig[4*j +: 4] != 4'h0) lz_sup = 0;
    end
    return lz_sup;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    k = 0;
    st_dig = '0; ac_dig = '0; st_dp = '0; ac_dp = '0;
    st_bl = '0; ac_bl = '0; st_bk = '0; ac_bk = '0;
    st_lz = 1'b0; ac_lz = 1'b0;
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] d, input logic [3:0] dpv,
                               input logic [3:0] bl, input logic [3:0] bk, input logic lz);
    int pos, mi, sc, frames;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    @(negedge clk);
    pos = k % FL;
    checkOutput("frame_tick", {31'b0, frame_tick}, {31'b0, pos == FL - 1});
    load = ld; digits = d; dp_in = dpv; blank_mask = bl; blink_mask = bk; lz_en = lz;
    @(posedge clk);
    mi = pos / SD;
    sc = pos % SD;
    frames = k / FL;
    exp_an = (sc < G) ? 4'hF : ~(4'b0001 << mi);
    if (ref_dark(mi, frames)) begin
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      exp_seg = ref_glyph(ac_dig[4*mi +: 4]);
      exp_dp  = ~ac_dp[mi];
    end
    if (pos == FL - 1) begin
      ac_dig = st_dig; ac_dp = st_dp; ac_bl = st_bl; ac_bk = st_bk; ac_lz = st_lz;
    end
    if (ld) begin
      st_dig = d; st_dp = dpv; st_bl = bl; st_bk = bk; st_lz = lz;
    end
    k++;
    #1;
    checkOutput("an", {28'b0, an}, {28'b0, exp_an});
    if (exp_an != 4'hF) begin
      checkOutput("seg", {25'b0, seg}, {25'b0, exp_seg});
      checkOutput("dp", {31'b0, dp}, {31'b0, exp_dp});
    end
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic run_until(input int p);
    while (k % FL != p) applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic check_dark_now(input string tag);
    checkOutput({tag, "_an"}, {28'b0, an}, 32'hF);
    checkOutput({tag, "_seg"}, {25'b0, seg}, 32'h7F);
    checkOutput({tag, "_dp"}, {31'b0, dp}, 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; digits = '0; dp_in = '0;
    blank_mask = '0; blink_mask = '0; lz_en = 1'b0;
    reset_model();
    #12;
    check_dark_now("in_reset");
    checkOutput("in_reset_tick", {31'b0, frame_tick}, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    $display("[TB] idle after reset");
    run_idle(40);

    $display("[TB] mid-frame load 12A0");
    run_until(6);
    applyStimulus(1'b1, 16'h12A0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    run_idle(40);

    $display("[TB] load in frame_tick cycle");
    run_until(FL - 1);
    applyStimulus(1'b1, 16'h9C5E, 4'b1001, 4'b0000, 4'b0000, 1'b0);
    run_idle(36);

    $display("[TB] leading zeros");
    run_until(3);
    applyStimulus(1'b1, 16'h0030, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    run_idle(36);
    applyStimulus(1'b1, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    run_idle(36);

    $display("[TB] blink and blank");
    applyStimulus(1'b1, 16'h7B8F, 4'b1111, 4'b1000, 4'b0001, 1'b0);
    run_idle(5 * FL);

    $display("[TB] randomized loads");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 11) == 0), 16'($urandom), 4'($urandom),
                    4'($urandom) & 4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("[TB] async reset mid-scan");
    run_until(11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_dark_now("async_rst");
    checkOutput("async_rst_tick", {31'b0, frame_tick}, 32'h0);
    @(posedge clk); #1;
    check_dark_now("held_rst");
    #1 rst_n = 1'b1;
    reset_model();
    run_idle(3 * FL);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
